// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous FIFO.
// Pointer widths and parameter legality are computed here so every user agrees.
package sync_fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic rdata_valid;
    } fifo_status_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit distinguishes full from empty when the low bits match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit fifo_params_legal(input int depth, input int af,
                                             input int ae, input int fwft);
        return (depth >= 2) && is_pow2(depth) &&
               (af >= 1) && (af <= depth) &&
               (ae >= 0) && (ae <= depth - 1) &&
               ((fwft == 0) || (fwft == 1));
    endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Storage array for sync_fifo_param: one write port, one registered read port
// and one combinational read port on the same read address.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_q,
    output logic [DATA_WIDTH-1:0] rd_data_async
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered port holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data_async = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost flags, occupancy count, flush and sticky error flags.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        write_en,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        read_en,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        rdata_valid,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = addr_width(FIFO_DEPTH);
    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    if (!fifo_params_legal(FIFO_DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_err
        $error("sync_fifo_param: illegal FIFO_DEPTH/AF_THRESH/AE_THRESH/FWFT");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         occ;
    logic                  empty_w;
    logic                  full_w;
    logic                  push;
    logic                  pop;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] ram_async;
    fifo_status_t          status;

    // Everything below decodes from the registered pointers only.
    assign occ     = wr_ptr - rd_ptr;
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A flush swallows any request in the same cycle.
    assign push = write_en & ~full_w & ~flush;
    assign pop  = read_en & ~empty_w & ~flush;

    // ---- stage p0 -> p1: pointer, flag and read-valid registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            vld_p1    <= pop;
            overflow  <= overflow | (write_en & full_w);
            underflow <= underflow | (read_en & empty_w);
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (push),
        .wr_addr       (wr_ptr[AW-1:0]),
        .wr_data       (wdata),
        .rd_en         (pop),
        .rd_addr       (rd_ptr[AW-1:0]),
        .rd_data_q     (ram_q),
        .rd_data_async (ram_async)
    );

    always_comb begin
        status              = '0;
        status.empty        = empty_w;
        status.full         = full_w;
        status.almost_empty = (occ <= AE_LVL);
        status.almost_full  = (occ >= AF_LVL);
        status.rdata_valid  = (FWFT != 0) ? ~empty_w : vld_p1;
    end

    // In fall-through mode the head word is presented whenever one exists.
    always_comb begin
        rdata = ram_q;
        if (FWFT != 0) begin
            rdata = empty_w ? '0 : ram_async;
        end
    end

    assign rdata_valid  = status.rdata_valid;
    assign empty        = status.empty;
    assign full         = status.full;
    assign almost_empty = status.almost_empty;
    assign almost_full  = status.almost_full;
    assign count        = occ;

endmodule
